gpu_pixel_arbiter: RTL and testbench
====================================

// Module: gpu_pixel_arbiter
// PURPOSE
// - Round-robin arbiter sharing the single pixel write port of gpu_memcontroller between the draw engines
//   (line, fill_rect, octantdraw, fill_circle); replaces the combinational busy-priority output decoder.
// - Engines offer pixels on a valid/ready handshake, so two engines may run concurrently without losing pixels.
// - One registered output stage isolates memcontroller timing.
// - Sequences frame flush: stops granting, drains the output stage, then pulses flush to memcontroller.
// PARAMETERS
// - NREQ    4             number of requesters (index 0 line, 1 fill, 2 arc, 3 circle)
// - XBITS   `WIDTH_BITS   x coordinate width
// - YBITS   `HEIGHT_BITS  y coordinate width
// PORTS
// - clk          in   1             system clock, rising edge
// - n_rst        in   1             asynchronous active-low reset
// - req_valid_i  in   NREQ          requester i presents a pixel
// - req_x_i      in   NREQ*XBITS    x of requester i at bits [i*XBITS +: XBITS]
// - req_y_i      in   NREQ*YBITS    y of requester i at bits [i*YBITS +: YBITS]
// - req_ready_o  out  NREQ          one-hot (or zero) accept to requester i
// - pix_valid_o  out  1             registered pixel valid toward memcontroller
// - pix_x_o      out  XBITS         registered pixel x
// - pix_y_o      out  YBITS         registered pixel y
// - pix_src_o    out  2             index of the requester that produced pix_*_o
// - pix_ready_i  in   1             memcontroller consumes pixel this cycle
// - flush_req_i  in   1             one-cycle flush request from gpu_controller
// - flush_o      out  1             one-cycle flush strobe to memcontroller
// - flush_ack_o  out  1             one-cycle completion strobe back to gpu_controller
// - idle_o       out  1             no pixel held, no flush pending, no req_valid_i set
// BEHAVIOUR
// - Reset (async, n_rst=0): pix_valid_o=0, pix_x_o=0, pix_y_o=0, pix_src_o=0, flush_o=0, flush_ack_o=0;
//   rr pointer=NREQ-1, so requester 0 has first priority; FSM=RUN.
// - Output register load enable: load = (!pix_valid_o || pix_ready_i) && state==RUN.
// - Grant: first i with req_valid_i[i], searching from ptr+1 modulo NREQ.
//   - req_ready_o[i] = load && grant==i; combinational from req_valid_i and state.
//   - No requests: req_ready_o=0.
// - Transfer on req_valid_i[i] && req_ready_o[i]:
//   - Next cycle, pix_valid_o=1 and pix_x/y/src_o reflect requester i. Latency is 1 cycle.
//   - ptr<=i.
//   - Throughput is 1 pixel/cycle while pix_ready_i=1.
// - pix_valid_o && pix_ready_i with no new transfer: pix_valid_o<=0. Data holds its last value.
// - pix_valid_o && !pix_ready_i: all outputs hold; req_ready_o=0 (full stall).
// - Requesters must hold valid and coordinates stable until accepted. The arbiter never drops a grant mid-stall.
// - Fairness: a continuously requesting engine waits at most NREQ-1 transfers.
// - FSM:
//   - RUN: flush_req_i -> DRAIN.
//   - DRAIN: granting is blocked; when !pix_valid_o, or pix_valid_o && pix_ready_i -> PULSE.
//   - PULSE: flush_o=1 and flush_ack_o=1 for exactly one cycle -> RUN.
// - flush_req_i while in DRAIN or PULSE is merged into the pending flush and produces no second pulse.
// - flush_req_i in the same cycle as a transfer: the transfer completes and the pixel drains before PULSE.
// - Pixels accepted before flush_o are always written before the flush.
// - Coordinates pass through unmodified; no bounds clipping (memcontroller owns clipping).
// - Reset mid-operation: any held pixel and pending flush are discarded; the next transfer uses requester-0 priority.
// STRUCTURE
// - Constants to place in gpu_definitions.vh:
//   - `REQ_LINE=0, `REQ_FILL=1, `REQ_ARC=2, `REQ_CIRCLE=3
//   - flush FSM state encoding RUN/DRAIN/PULSE (2 bits)
// - One sub-module: gpu_rr_arbiter (parameter NREQ; inputs req, ptr, en; output one-hot grant). Purely combinational, reusable.
// - Top holds the rr pointer, output register and flush FSM.
// TESTING
// - Single source: req_valid_i=0001 (5,7), pix_ready_i=1
//   -> req_ready_o=0001 same cycle; next cycle pix_valid_o=1, x=5, y=7, src=0.
// - Rotation: all four valid continuously, pix_ready_i=1
//   -> grants 0,1,2,3,0,... one per cycle; no requester starved.
// - Backpressure: pixel held, pix_ready_i=0 for 3 cycles
//   -> outputs stable, req_ready_o=0; on release, the next grant is loaded the same cycle.
// - Flush drain: pixel held, pix_ready_i=0, flush_req_i pulse
//   -> no grants; flush_o/flush_ack_o pulse exactly 1 cycle after the pixel is consumed; a second flush_req_i in DRAIN yields one pulse.
// - Async reset mid-stall: n_rst low with pix_valid_o=1
//   -> immediately pix_valid_o=0; after release, requesters 0 and 3 both valid -> 0 is granted first.

Source files
------------

// File: rtl/gpu_pixel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pixel_arbiter_pkg
// Brief    : Shared constants and types for the GPU pixel write-port arbiter
//            (requester indices, flush FSM encoding, pointer width helper).
// Revision : 1.0 - initial release
// ============================================================================
package gpu_pixel_arbiter_pkg;

    // Requester slot assignment on the shared pixel port
    localparam int REQ_LINE   = 0;
    localparam int REQ_FILL   = 1;
    localparam int REQ_ARC    = 2;
    localparam int REQ_CIRCLE = 3;

    // Default screen coordinate widths (1024 x 512 framebuffer)
    localparam int DEF_XBITS  = 10;
    localparam int DEF_YBITS  = 9;

    // Flush sequencer states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_PULSE = 2'd2
    } flush_state_e;

    // Width of an index into NREQ requesters (at least one bit)
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpu_rr_arbiter
// Brief    : Combinational round-robin grant. Searches req starting one slot
//            after ptr (wrapping) and returns a one-hot grant, or zero when
//            en is low or nothing is requesting.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_rr_arbiter
    import gpu_pixel_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]           req_i,
    input  logic [ptr_bits(NREQ)-1:0] ptr_i,
    input  logic                      en_i,
    output logic [NREQ-1:0]           grant_o
);

    localparam int PW = ptr_bits(NREQ);

    logic          found;
    logic [PW-1:0] idx;

    // First requester after the last winner, wrapping modulo NREQ
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr_i) + k) % NREQ);
            if (en_i && !found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpu_pixel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pixel_arbiter
// Brief    : Shares the memcontroller pixel write port between the draw
//            engines with round-robin valid/ready arbitration, a single
//            registered output stage and a drain-then-pulse flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_pixel_arbiter
    import gpu_pixel_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int XBITS = DEF_XBITS,
    parameter int YBITS = DEF_YBITS
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*XBITS-1:0] req_x_i,
    input  logic [NREQ*YBITS-1:0] req_y_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  pix_valid_o,
    output logic [XBITS-1:0]      pix_x_o,
    output logic [YBITS-1:0]      pix_y_o,
    output logic [1:0]            pix_src_o,
    input  logic                  pix_ready_i,
    input  logic                  flush_req_i,
    output logic                  flush_o,
    output logic                  flush_ack_o,
    output logic                  idle_o
);

    localparam int PW = ptr_bits(NREQ);

    flush_state_e     state_q, state_d;
    logic             flush_q, flush_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             pix_valid_q, pix_valid_d;
    logic [XBITS-1:0] pix_x_q, pix_x_d;
    logic [YBITS-1:0] pix_y_q, pix_y_d;
    logic [1:0]       pix_src_q, pix_src_d;

    logic             load;
    logic [NREQ-1:0]  grant;
    logic             grant_any;
    logic [PW-1:0]    grant_idx;
    logic [XBITS-1:0] sel_x;
    logic [YBITS-1:0] sel_y;

    // Output stage can take a new pixel when empty or being consumed, and only outside a flush
    assign load = (!pix_valid_q || pix_ready_i) && (state_q == ST_RUN);

    gpu_rr_arbiter #(
        .NREQ    (NREQ)
    ) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .en_i    (load),
        .grant_o (grant)
    );

    assign req_ready_o = grant;
    assign grant_any   = |grant;

    // Encode the one-hot grant and select the winning coordinates
    always_comb begin
        grant_idx = '0;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
                sel_x     = req_x_i[i*XBITS +: XBITS];
                sel_y     = req_y_i[i*YBITS +: YBITS];
            end
        end
    end

    // Output register: load on transfer, clear valid on consumption, otherwise hold
    always_comb begin
        pix_valid_d = pix_valid_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_src_d   = pix_src_q;
        ptr_d       = ptr_q;
        if (grant_any) begin
            pix_valid_d = 1'b1;
            pix_x_d     = sel_x;
            pix_y_d     = sel_y;
            pix_src_d   = 2'(grant_idx);
            ptr_d       = grant_idx;
        end else if (pix_valid_q && pix_ready_i) begin
            pix_valid_d = 1'b0;
        end
    end

    // Flush sequencer: extra requests while draining or pulsing are absorbed
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pix_valid_q || pix_ready_i) begin
                    state_d = ST_PULSE;
                    flush_d = 1'b1;
                end
            end
            ST_PULSE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers; reset favours requester 0 first
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_RUN;
            flush_q     <= 1'b0;
            ptr_q       <= PW'(NREQ - 1);
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            ptr_q       <= ptr_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_src_q   <= pix_src_d;
        end
    end

    assign pix_valid_o = pix_valid_q;
    assign pix_x_o     = pix_x_q;
    assign pix_y_o     = pix_y_q;
    assign pix_src_o   = pix_src_q;
    assign flush_o     = flush_q;
    assign flush_ack_o = flush_q;
    assign idle_o      = !pix_valid_q && (state_q == ST_RUN) && !(|req_valid_i);

endmodule
`default_nettype wire

// File: tb/tb_gpu_pixel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpu_pixel_arbiter
// Brief    : Self-checking bench for gpu_pixel_arbiter: directed scenarios
//            plus randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_pixel_arbiter;
    import gpu_pixel_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int XB   = DEF_XBITS;
    localparam int YB   = DEF_YBITS;

    logic               clk = 1'b0;
    logic               n_rst = 1'b0;
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ*XB-1:0] req_x_i;
    logic [NREQ*YB-1:0] req_y_i;
    logic [NREQ-1:0]    req_ready_o;
    logic               pix_valid_o;
    logic [XB-1:0]      pix_x_o;
    logic [YB-1:0]      pix_y_o;
    logic [1:0]         pix_src_o;
    logic               pix_ready_i;
    logic               flush_req_i;
    logic               flush_o;
    logic               flush_ack_o;
    logic               idle_o;

    gpu_pixel_arbiter #(.NREQ(NREQ), .XBITS(XB), .YBITS(YB)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_valid_i (req_valid_i),
        .req_x_i     (req_x_i),
        .req_y_i     (req_y_i),
        .req_ready_o (req_ready_o),
        .pix_valid_o (pix_valid_o),
        .pix_x_o     (pix_x_o),
        .pix_y_o     (pix_y_o),
        .pix_src_o   (pix_src_o),
        .pix_ready_i (pix_ready_i),
        .flush_req_i (flush_req_i),
        .flush_o     (flush_o),
        .flush_ack_o (flush_ack_o),
        .idle_o      (idle_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cx[NREQ];
    int cy[NREQ];

    // Transaction-level model: held pixel, last winner, flush pending / pulsing
    bit            m_valid;
    logic [XB-1:0] m_x;
    logic [YB-1:0] m_y;
    int            m_src;
    int            m_ptr;
    bit            m_drain;
    bit            m_pulse;
    int            last_acc;

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            req_x_i[i*XB +: XB] = XB'(cx[i]);
            req_y_i[i*YB +: YB] = YB'(cy[i]);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_x = '0; m_y = '0; m_src = 0;
        m_ptr = NREQ - 1; m_drain = 0; m_pulse = 0; last_acc = -1;
    endtask

    // Who should be accepted right now under the round-robin rule
    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r = '0;
        if (m_drain || m_pulse) return r;
        if (m_valid && !pix_ready_i) return r;
        for (int k = 1; k <= NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            if (req_valid_i[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // Advance one clock: capture inputs, step the model, settle 1 time unit past the edge
    task automatic tick();
        logic [NREQ-1:0] rdy;
        logic pr, fr, was_valid;
        rdy = model_ready();
        pr = pix_ready_i;
        fr = flush_req_i;
        was_valid = m_valid;
        @(posedge clk);
        if (m_pulse) m_pulse = 0;
        else if (m_drain) begin
            if (!was_valid || pr) begin m_drain = 0; m_pulse = 1; end
        end else if (fr) m_drain = 1;
        last_acc = -1;
        for (int i = 0; i < NREQ; i++) if (rdy[i]) last_acc = i;
        if (last_acc >= 0) begin
            m_valid = 1; m_x = XB'(cx[last_acc]); m_y = YB'(cy[last_acc]);
            m_src = last_acc; m_ptr = last_acc;
        end else if (was_valid && pr) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        #2 n_rst = 1'b0;
        model_reset();
        @(posedge clk);
        #2 n_rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req_valid_i = '0; pix_ready_i = 1'b0; flush_req_i = 1'b0;
        for (int i = 0; i < NREQ; i++) begin cx[i] = 0; cy[i] = 0; end
        pack();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pix_valid_o, pix_x_o, pix_y_o, pix_src_o, flush_o, flush_ack_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b x=%0d y=%0d src=%0d flush=%0b ack=%0b, required all zero",
                     pix_valid_o, pix_x_o, pix_y_o, pix_src_o, flush_o, flush_ack_o);
        end
        checks++;
        if (idle_o !== 1'b1) begin
            errors++; $display("FAIL reset_idle: got %0b required 1", idle_o);
        end
        #3 n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        cx[REQ_LINE] = 5; cy[REQ_LINE] = 7; pack();
        req_valid_i = 4'b0001; pix_ready_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0001) begin
            errors++; $display("FAIL single_ready: got %b required 0001", req_ready_o);
        end
        tick();
        req_valid_i = '0;
        checks++;
        if (pix_valid_o !== 1'b1 || pix_x_o !== XB'(5) || pix_y_o !== YB'(7) || pix_src_o !== 2'd0) begin
            errors++;
            $display("FAIL single_pixel: valid=%0b x=%0d y=%0d src=%0d required 1 5 7 0",
                     pix_valid_o, pix_x_o, pix_y_o, pix_src_o);
        end
        tick();
        checks++;
        if (pix_valid_o !== 1'b0 || pix_x_o !== XB'(5) || pix_y_o !== YB'(7)) begin
            errors++;
            $display("FAIL single_consume: valid=%0b x=%0d y=%0d required 0 5 7", pix_valid_o, pix_x_o, pix_y_o);
        end
    endtask

    task automatic test_rotation();
        int cnt[NREQ];
        do_reset();
        for (int i = 0; i < NREQ; i++) begin cx[i] = 10*i + 1; cy[i] = 20*i + 2; cnt[i] = 0; end
        pack();
        req_valid_i = '1; pix_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [NREQ-1:0] exp_r;
            exp_r = '0;
            exp_r[k % NREQ] = 1'b1;
            #1;
            checks++;
            if (req_ready_o !== exp_r) begin
                errors++; $display("FAIL rotation_ready[%0d]: got %b required %b", k, req_ready_o, exp_r);
            end
            tick();
            checks++;
            if (pix_valid_o !== 1'b1 || pix_src_o !== 2'(k % NREQ) || pix_x_o !== XB'(10*(k%NREQ)+1)) begin
                errors++;
                $display("FAIL rotation_pixel[%0d]: valid=%0b src=%0d x=%0d required 1 %0d %0d",
                         k, pix_valid_o, pix_src_o, pix_x_o, k % NREQ, 10*(k%NREQ)+1);
            end else cnt[k % NREQ]++;
        end
        checks++;
        if (cnt[0] < 2 || cnt[1] < 2 || cnt[2] < 2 || cnt[3] < 2) begin
            errors++; $display("FAIL rotation_fairness: counts %0d %0d %0d %0d required >=2 each",
                               cnt[0], cnt[1], cnt[2], cnt[3]);
        end
    endtask

    task automatic test_backpressure();
        // pixel from requester 3 held, all four still requesting
        pix_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready_o !== '0) begin
                errors++; $display("FAIL stall_ready[%0d]: got %b required 0000", c, req_ready_o);
            end
            tick();
            checks++;
            if (pix_valid_o !== 1'b1 || pix_src_o !== 2'd3 || pix_x_o !== XB'(31) || pix_y_o !== YB'(62)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%0b src=%0d x=%0d y=%0d required 1 3 31 62",
                         c, pix_valid_o, pix_src_o, pix_x_o, pix_y_o);
            end
        end
        pix_ready_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0001) begin
            errors++; $display("FAIL stall_release_ready: got %b required 0001", req_ready_o);
        end
        tick();
        checks++;
        if (pix_valid_o !== 1'b1 || pix_src_o !== 2'd0) begin
            errors++; $display("FAIL stall_release_pixel: valid=%0b src=%0d required 1 0", pix_valid_o, pix_src_o);
        end
        req_valid_i = '0;
        tick();
    endtask

    task automatic test_flush();
        cx[REQ_FILL] = 100; cy[REQ_FILL] = 200; pack();
        req_valid_i = 4'b0010; pix_ready_i = 1'b1;
        tick();
        req_valid_i = 4'b0100; pix_ready_i = 1'b0; flush_req_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== '0) begin
            errors++; $display("FAIL flush_stall_ready: got %b required 0000", req_ready_o);
        end
        tick();
        flush_req_i = 1'b0;
        tick();
        checks++;
        if (flush_o !== 1'b0 || req_ready_o !== '0 || pix_src_o !== 2'd1) begin
            errors++; $display("FAIL flush_drain_wait: flush=%0b ready=%b src=%0d required 0 0000 1",
                               flush_o, req_ready_o, pix_src_o);
        end
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        pix_ready_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== '0) begin
            errors++; $display("FAIL flush_drain_block: got %b required 0000", req_ready_o);
        end
        tick();
        checks++;
        if (flush_o !== 1'b1 || flush_ack_o !== 1'b1 || pix_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_pulse: flush=%0b ack=%0b valid=%0b required 1 1 0",
                               flush_o, flush_ack_o, pix_valid_o);
        end
        checks++;
        if (req_ready_o !== '0) begin
            errors++; $display("FAIL flush_pulse_ready: got %b required 0000", req_ready_o);
        end
        tick();
        checks++;
        if (flush_o !== 1'b0 || flush_ack_o !== 1'b0 || req_ready_o !== 4'b0100) begin
            errors++; $display("FAIL flush_after: flush=%0b ack=%0b ready=%b required 0 0 0100",
                               flush_o, flush_ack_o, req_ready_o);
        end
        tick();
        req_valid_i = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (flush_o !== 1'b0) begin
                errors++; $display("FAIL flush_single_pulse[%0d]: flush=%0b required 0", c, flush_o);
            end
        end
    endtask

    task automatic test_async_reset();
        cx[REQ_ARC] = 9; cy[REQ_ARC] = 3; cx[REQ_CIRCLE] = 44; cy[REQ_CIRCLE] = 55;
        cx[REQ_LINE] = 12; cy[REQ_LINE] = 34; pack();
        req_valid_i = 4'b0100; pix_ready_i = 1'b0;
        tick();
        tick();
        #1 n_rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pix_valid_o !== 1'b0) begin
            errors++; $display("FAIL async_reset_valid: got %0b required 0", pix_valid_o);
        end
        @(posedge clk);
        #2 n_rst = 1'b1;
        req_valid_i = 4'b1001; pix_ready_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0001) begin
            errors++; $display("FAIL async_reset_priority: got %b required 0001", req_ready_o);
        end
        tick();
        checks++;
        if (pix_src_o !== 2'd0 || pix_x_o !== XB'(12)) begin
            errors++; $display("FAIL async_reset_pixel: src=%0d x=%0d required 0 12", pix_src_o, pix_x_o);
        end
        req_valid_i = 4'b1000;
        tick();
        req_valid_i = '0;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid_i[i] && $urandom_range(0, 1) == 1) begin
                    cx[i] = int'($urandom % (1 << XB));
                    cy[i] = int'($urandom % (1 << YB));
                    req_valid_i[i] = 1'b1;
                end
            end
            pack();
            pix_ready_i = ($urandom_range(0, 9) < 7);
            flush_req_i = ($urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (req_ready_o !== model_ready()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b required %b", n, req_ready_o, model_ready());
            end
            checks++;
            if (idle_o !== (!m_valid && !m_drain && !m_pulse && req_valid_i == '0)) begin
                errors++; $display("FAIL rand_idle[%0d]: got %0b", n, idle_o);
            end
            tick();
            checks++;
            if (pix_valid_o !== m_valid || pix_x_o !== m_x || pix_y_o !== m_y || pix_src_o !== 2'(m_src)) begin
                errors++;
                $display("FAIL rand_pixel[%0d]: valid=%0b x=%0d y=%0d src=%0d required %0b %0d %0d %0d",
                         n, pix_valid_o, pix_x_o, pix_y_o, pix_src_o, m_valid, m_x, m_y, m_src);
            end
            checks++;
            if (flush_o !== m_pulse || flush_ack_o !== m_pulse) begin
                errors++; $display("FAIL rand_flush[%0d]: flush=%0b ack=%0b required %0b",
                                   n, flush_o, flush_ack_o, m_pulse);
            end
            if (last_acc >= 0) req_valid_i[last_acc] = 1'b0;
        end
        flush_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
